// File: rtl/pipe_div_unit.sv
// Multi-cycle restoring divider holding the HI/LO registers for div/divu and mthi/mtlo.
// A division takes 33 cycles from the start edge until HI/LO are written and done pulses.
module pipe_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        w_hi,
  input  logic        w_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    a_mag  = (sign && dividend[31]) ? (~dividend + 32'd1) : dividend;
    b_mag  = (sign && divisor[31])  ? (~divisor + 32'd1)  : divisor;
    // quo_q doubles as the dividend shift register: its MSB feeds the remainder.
    rem_sh = {rem_q, quo_q[31]};
    diff   = rem_sh - {1'b0, dvs_q};

    if (w_hi) hi_d = wdata;
    if (w_lo) lo_d = wdata;

    case (state_q)
      StIdle: begin
        if (start) begin
          quo_d   = a_mag;
          dvs_d   = b_mag;
          rem_d   = 32'd0;
          cnt_d   = 5'd0;
          neg_q_d = sign && (dividend[31] ^ divisor[31]);
          neg_r_d = sign && dividend[31];
          dz_d    = (divisor == 32'd0);
          state_d = StCalc;
        end
      end
      StCalc: begin
        rem_d = diff[32] ? rem_sh[31:0] : diff[31:0];
        quo_d = {quo_q[30:0], ~diff[32]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StFinish;
      end
      StFinish: begin
        // Result wins over a same-cycle mthi/mtlo.
        lo_d    = dz_q ? 32'hFFFF_FFFF : (neg_q_q ? (~quo_q + 32'd1) : quo_q);
        hi_d    = neg_r_q ? (~rem_q + 32'd1) : rem_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/pipe_div_unit.md
PIPE_DIV_UNIT -- requirements
Module: pipe_div_unit

Interface
REQ-001: clk  input  1  single clock; all state updates on the rising edge.
REQ-002: rst_n  input  1  asynchronous reset, active-low.
REQ-003: start  input  1  issue pulse from the EX stage for div/divu (already qualified by ~stall).
REQ-004: sign  input  1  1 = div (signed), 0 = divu (unsigned); sampled with start.
REQ-005: dividend  input  32  rs operand (post-forwarding); sampled with start.
REQ-006: divisor  input  32  rt operand (post-forwarding); sampled with start.
REQ-007: w_hi  input  1  mthi write enable.
REQ-008: w_lo  input  1  mtlo write enable.
REQ-009: wdata  input  32  mthi/mtlo data.
REQ-010: busy  output  1  division in progress; the ID control unit ORs this into stall for mfhi/mflo/div/divu/mthi/mtlo.
REQ-011: done  output  1  one-cycle pulse; the HI/LO result became visible this cycle.
REQ-012: hi  output  32  HI register (remainder).
REQ-013: lo  output  32  LO register (quotient).

Function
REQ-014: FSM states: IDLE, CALC, FINISH; busy SHALL be 1 whenever state != IDLE.
REQ-015: IDLE with start=1 at edge E0 SHALL latch operand magnitudes, sign flags and divisor, clear the partial remainder, load a 5-bit iteration counter = 0, and enter CALC.
REQ-016: start SHALL be ignored while busy=1; no operands are relatched.
REQ-017: CALC SHALL perform one restoring shift-subtract step per edge (E1..E32), producing one quotient bit MSB-first; at counter = 31 it SHALL enter FINISH.
REQ-018: Arithmetic on 32-bit unsigned magnitudes with a 33-bit subtract; |0x80000000| = 0x80000000 unsigned.
REQ-019: FINISH at edge E33 SHALL write lo <= quotient, hi <= remainder, assert done for exactly the following cycle, and return to IDLE.
REQ-020: Total latency: start at E0 -> result in hi/lo and done=1 after E33; busy high E0..E33 (33 cycles).
REQ-021: Signed mode: quotient negated iff operand signs differ; remainder takes the sign of the dividend; a zero result is never negated.
REQ-022: Signed 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000, hi = 0x00000000 (no trap).
REQ-023: Divisor = 0 (either mode) SHALL still take 33 cycles and give lo = 0xFFFFFFFF, hi = dividend as sampled.
REQ-024: w_hi/w_lo SHALL update hi/lo at the next edge in any state; at E33 the division result overrides a simultaneous mthi/mtlo to the same register.
REQ-025: hi/lo SHALL hold their values in all cycles without a write.
REQ-026: start and done coinciding (back-to-back issue after E33) SHALL be accepted normally from IDLE.

Reset
REQ-027: rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, regardless of clock.
REQ-028: Reset asserted mid-CALC SHALL discard the operation; after release no done pulse occurs and hi/lo remain 0.
REQ-029: The first start is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-030: divu 100 / 7 -> busy high 33 cycles, then done pulse, lo = 14, hi = 2.
REQ-031: div 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; div 7 / 0xFFFFFFFE -> lo = 0xFFFFFFFD, hi = 1.
REQ-032: div 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0; divu 0x12345678 / 0 -> lo = 0xFFFFFFFF, hi = 0x12345678.
REQ-033: second start at cycle 5 with different operands while busy -> ignored; result equals the first operation's, single done pulse.
REQ-034: rst_n pulsed low at cycle 10 of a divide -> busy = 0 at once, hi = lo = 0, no done within the next 40 cycles.
REQ-035: w_hi with 0xAAAA5555 at cycle 10 of a divide -> hi = 0xAAAA5555 until E33, then the division remainder; w_lo at E33 -> lo = division quotient.
